axi_capture_slave: RTL and testbench

AXI_CAPTURE_SLAVE -- requirements
Module: axi_capture_slave

---
 rtl/axi_capture_slave.sv | 218 +++++++++++++++++++++
 tb/tb_axi_capture_slave.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_capture_slave.sv
// axi_capture_slave: single-beat AXI4 slave backed by a small byte-maskable word array.
// Writes accept AW and W in either order; reads run on an independent path.
// Build option: define AXI_CAPTURE_COUNT_EN to add wr_count_o, a saturating count of OKAY writes.
module axi_capture_slave #(
  parameter int unsigned                AXI_ID_WIDTH   = 10,
  parameter int unsigned                AXI_ADDR_WIDTH = 64,
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = AXI_ADDR_WIDTH'(64'h9000_0000),
  parameter int unsigned                NUM_WORDS      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic                        r_valid_o,
  input  logic                        r_ready_i
`ifdef AXI_CAPTURE_COUNT_EN
  ,
  output logic [15:0]                 wr_count_o
`endif
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] WIN_BYTES = AXI_ADDR_WIDTH'(NUM_WORDS * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [AXI_DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  logic [AXI_ID_WIDTH-1:0]   aw_id_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]                aw_len_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic                      w_last_q;
  logic [1:0]                b_resp_q;

  logic                      aw_hs, w_hs, ar_hs, wr_commit, wr_legal, rd_legal;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [7:0]                wr_len;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_last;
  logic [IDX_W-1:0]          wr_idx, rd_idx;
  logic                      unused_ok;

  assign unused_ok = ^aw_size_i;

  // Write FSM: next state plus AW/W readies and B valid
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        w_ready_o  = 1'b1;
        if (aw_valid_i && w_valid_i) w_state_d = W_RESP;
        else if (aw_valid_i)         w_state_d = W_HAVE_AW;
        else if (w_valid_i)          w_state_d = W_HAVE_W;
      end
      W_HAVE_AW: begin
        w_ready_o = 1'b1;
        if (w_valid_i) w_state_d = W_RESP;
      end
      W_HAVE_W: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs     = aw_valid_i && aw_ready_o;
  assign w_hs      = w_valid_i && w_ready_o;
  assign wr_commit = (w_state_q != W_RESP) && (w_state_d == W_RESP);

  // Commit uses this cycle's handshake payload when it arrives now, else the captured one
  assign wr_addr  = aw_hs ? aw_addr_i : aw_addr_q;
  assign wr_len   = aw_hs ? aw_len_i  : aw_len_q;
  assign wr_data  = w_hs  ? w_data_i  : w_data_q;
  assign wr_strb  = w_hs  ? w_strb_i  : w_strb_q;
  assign wr_last  = w_hs  ? w_last_i  : w_last_q;
  assign wr_off   = wr_addr - BASE_ADDR;
  assign wr_idx   = wr_off[OFF_W +: IDX_W];
  assign wr_legal = (wr_off < WIN_BYTES) && (wr_len == 8'd0) && wr_last;

  assign b_id_o   = aw_id_q;
  assign b_resp_o = b_resp_q;

  // Write state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  // Capture AW/W payloads at handshake; latch response at commit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
      b_resp_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_id_q   <= aw_id_i;
        aw_addr_q <= aw_addr_i;
        aw_len_q  <= aw_len_i;
      end
      if (w_hs) begin
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
        w_last_q <= w_last_i;
      end
      if (wr_commit) b_resp_q <= wr_legal ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Storage array: byte-masked write on legal commit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_commit && wr_legal) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (wr_strb[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  // Read FSM: next state plus AR ready and R valid
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) r_state_d = R_RESP;
      end
      R_RESP: begin
        r_valid_o = 1'b1;
        if (r_ready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs    = ar_valid_i && ar_ready_o;
  assign rd_off   = ar_addr_i - BASE_ADDR;
  assign rd_idx   = rd_off[OFF_W +: IDX_W];
  assign rd_legal = (rd_off < WIN_BYTES) && (ar_len_i == 8'd0);
  assign r_last_o = r_valid_o;

  // Read state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  // Read payload registered at AR handshake; array read sees pre-commit contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id_o   <= '0;
      r_data_o <= '0;
      r_resp_o <= '0;
    end else if (ar_hs) begin
      r_id_o   <= ar_id_i;
      r_data_o <= rd_legal ? mem_q[rd_idx] : '0;
      r_resp_o <= rd_legal ? RESP_OKAY : RESP_SLVERR;
    end
  end

`ifdef AXI_CAPTURE_COUNT_EN
  // Saturating count of OKAY write commits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_count_o <= '0;
    else if (wr_commit && wr_legal && (wr_count_o != '1)) wr_count_o <= wr_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axi_capture_slave.sv
// tb_axi_capture_slave: directed and randomized checks of axi_capture_slave against
// a byte-level memory model. Define AXI_CAPTURE_COUNT_EN to also check wr_count_o.
module tb_axi_capture_slave;

  localparam int unsigned IDW = 10;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned NW  = 8;
  localparam logic [63:0] BASE = 64'h9000_0000;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [IDW-1:0] aw_id;
  logic [AW-1:0]  aw_addr;
  logic [7:0]     aw_len;
  logic [2:0]     aw_size;
  logic           aw_valid;
  logic           aw_ready;
  logic [DW-1:0]  w_data;
  logic [DW/8-1:0] w_strb;
  logic           w_last;
  logic           w_valid;
  logic           w_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic           b_valid;
  logic           b_ready;
  logic [IDW-1:0] ar_id;
  logic [AW-1:0]  ar_addr;
  logic [7:0]     ar_len;
  logic           ar_valid;
  logic           ar_ready;
  logic [IDW-1:0] r_id;
  logic [DW-1:0]  r_data;
  logic [1:0]     r_resp;
  logic           r_last;
  logic           r_valid;
  logic           r_ready;
`ifdef AXI_CAPTURE_COUNT_EN
  logic [15:0]    wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] model_mem [NW];
  int unsigned model_cnt;

  axi_capture_slave #(
    .AXI_ID_WIDTH   (IDW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .BASE_ADDR      (BASE),
    .NUM_WORDS      (NW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .aw_id_i    (aw_id),
    .aw_addr_i  (aw_addr),
    .aw_len_i   (aw_len),
    .aw_size_i  (aw_size),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_last_i   (w_last),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .b_id_o     (b_id),
    .b_resp_o   (b_resp),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .ar_id_i    (ar_id),
    .ar_addr_i  (ar_addr),
    .ar_len_i   (ar_len),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .r_id_o     (r_id),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_last_o   (r_last),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready)
`ifdef AXI_CAPTURE_COUNT_EN
    ,
    .wr_count_o (wr_count)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Model: a write is legal inside the byte window with a single, last beat
  function automatic logic legal_wr(input logic [63:0] addr, input logic [7:0] len, input logic last);
    return (addr >= BASE) && (addr < BASE + 64'(NW * 8)) && (len == 8'd0) && last;
  endfunction

  function automatic logic legal_rd(input logic [63:0] addr, input logic [7:0] len);
    return (addr >= BASE) && (addr < BASE + 64'(NW * 8)) && (len == 8'd0);
  endfunction

  function automatic int unsigned word_of(input logic [63:0] addr);
    logic [63:0] w;
    w = (addr - BASE) / 64'd8;
    return 32'(w);
  endfunction

  task automatic model_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int unsigned k;
    k = word_of(addr);
    for (int b = 0; b < 8; b++)
      if (strb[b]) model_mem[k][b*8 +: 8] = data[b*8 +: 8];
    if (model_cnt < 32'hFFFF) model_cnt++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) model_mem[i] = '0;
    model_cnt = 0;
  endtask

  // Issue AW and W together and collect the B response
  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [63:0] data,
                          input logic [7:0] strb, input logic last, input logic [IDW-1:0] id,
                          output logic [1:0] resp, output logic [IDW-1:0] bid, output int lat);
    int n;
    logic aw_go, w_go;
    @(negedge clk_i);
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_id = id; aw_size = 3'd3;
    w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
    n = 0;
    while ((aw_valid || w_valid) && n < 20) begin
      aw_go = aw_valid && aw_ready;
      w_go  = w_valid && w_ready;
      @(negedge clk_i);
      if (aw_go) aw_valid = 1'b0;
      if (w_go)  w_valid = 1'b0;
      n++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    lat = 0;
    while (!b_valid && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    n_cmp++;
    if (b_valid !== 1'b1 || n >= 20) begin
      n_err++;
      $display("FAIL b_timeout: b_valid=%b handshake_cycles=%0d required b_valid=1 within bound", b_valid, n);
    end
    resp = b_resp;
    bid  = b_id;
    b_ready = 1'b1;
    @(negedge clk_i);
    b_ready = 1'b0;
  endtask

  // Issue AR and collect the R beat
  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                         output logic [63:0] data, output logic [1:0] resp,
                         output logic last, output logic [IDW-1:0] rid);
    int n;
    @(negedge clk_i);
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_id = id;
    n = 0;
    while (!ar_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    ar_valid = 1'b0;
    while (!r_valid && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    n_cmp++;
    if (r_valid !== 1'b1) begin
      n_err++;
      $display("FAIL r_timeout: r_valid=%b required 1 within bound", r_valid);
    end
    data = r_data; resp = r_resp; last = r_last; rid = r_id;
    r_ready = 1'b1;
    @(negedge clk_i);
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    aw_valid = 0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0; r_ready = 0;
    model_clear();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({b_valid, r_valid, b_id, b_resp, r_id, r_data, r_resp} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: b_valid=%b r_valid=%b b_id=%h b_resp=%h r_id=%h r_data=%h r_resp=%h required all 0",
               b_valid, r_valid, b_id, b_resp, r_id, r_data, r_resp);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_cmp++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_readies: got %b required 111", {aw_ready, w_ready, ar_ready});
    end
`ifdef AXI_CAPTURE_COUNT_EN
    n_cmp++;
    if (wr_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d required 0", wr_count);
    end
`endif
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [IDW-1:0] bid, rid; int lat; logic [63:0] d; logic last;
    do_write(BASE, 8'd0, 64'hDEAD_BEEF_1234_5678, 8'hFF, 1'b1, 10'h155, resp, bid, lat);
    model_write(BASE, 64'hDEAD_BEEF_1234_5678, 8'hFF);
    n_cmp++;
    if (lat !== 0 || resp !== 2'b00 || bid !== 10'h155) begin
      n_err++;
      $display("FAIL basic_b: lat=%0d resp=%b id=%h required lat=0 resp=00 id=155", lat, resp, bid);
    end
    do_read(BASE, 8'd0, 10'h2A3, d, resp, last, rid);
    n_cmp++;
    if (d !== 64'hDEAD_BEEF_1234_5678 || resp !== 2'b00 || last !== 1'b1 || rid !== 10'h2A3) begin
      n_err++;
      $display("FAIL basic_r: data=%h resp=%b last=%b id=%h required DEADBEEF12345678 00 1 2a3", d, resp, last, rid);
    end
  endtask

  task automatic test_split();
    logic [1:0] resp; logic [IDW-1:0] rid; logic [63:0] d; logic last;
    @(negedge clk_i);
    w_valid = 1'b1; w_data = 64'h1111_2222_3333_4444; w_strb = 8'h0F; w_last = 1'b1;
    @(negedge clk_i);
    w_valid = 1'b0;
    n_cmp++;
    if ({aw_ready, w_ready, b_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL split_have_w: aw_ready,w_ready,b_valid=%b required 100", {aw_ready, w_ready, b_valid});
    end
    @(negedge clk_i);
    @(negedge clk_i);
    aw_valid = 1'b1; aw_addr = BASE + 64'h8; aw_len = 8'd0; aw_id = 10'h0C3;
    @(negedge clk_i);
    aw_valid = 1'b0;
    n_cmp++;
    if ({b_valid, b_resp, b_id} !== {1'b1, 2'b00, 10'h0C3}) begin
      n_err++;
      $display("FAIL split_b: b_valid=%b resp=%b id=%h required 1 00 0c3", b_valid, b_resp, b_id);
    end
    b_ready = 1'b1;
    @(negedge clk_i);
    b_ready = 1'b0;
    model_write(BASE + 64'h8, 64'h1111_2222_3333_4444, 8'h0F);
    do_read(BASE + 64'h8, 8'd0, 10'h001, d, resp, last, rid);
    n_cmp++;
    if (d !== 64'h0000_0000_3333_4444 || d !== model_mem[1] || resp !== 2'b00) begin
      n_err++;
      $display("FAIL split_r: data=%h resp=%b required 0000000033334444 00", d, resp);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [IDW-1:0] bid, rid; int lat; logic [63:0] d; logic last;
    logic [63:0] a [4];
    logic [7:0]  l [4];
    logic        t [4];
    a[0] = BASE + 64'h100; l[0] = 8'd0; t[0] = 1'b1;
    a[1] = BASE + 64'h10;  l[1] = 8'd1; t[1] = 1'b1;
    a[2] = BASE - 64'h8;   l[2] = 8'd0; t[2] = 1'b1;
    a[3] = BASE + 64'h18;  l[3] = 8'd0; t[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_write(a[i], l[i], {$urandom, $urandom}, 8'hFF, t[i], 10'(i + 7), resp, bid, lat);
      n_cmp++;
      if (resp !== 2'b10 || bid !== 10'(i + 7)) begin
        n_err++;
        $display("FAIL slverr_b%0d: resp=%b id=%h required 10 %h", i, resp, bid, 10'(i + 7));
      end
    end
    for (int i = 0; i < NW; i++) begin
      do_read(BASE + 64'(i * 8), 8'd0, 10'(i), d, resp, last, rid);
      n_cmp++;
      if (d !== model_mem[i] || resp !== 2'b00) begin
        n_err++;
        $display("FAIL slverr_mem%0d: data=%h resp=%b required %h 00", i, d, resp, model_mem[i]);
      end
    end
    do_read(BASE + 64'h40, 8'd0, 10'h3FF, d, resp, last, rid);
    n_cmp++;
    if (d !== 64'd0 || resp !== 2'b10 || last !== 1'b1 || rid !== 10'h3FF) begin
      n_err++;
      $display("FAIL slverr_rd_oob: data=%h resp=%b last=%b id=%h required 0 10 1 3ff", d, resp, last, rid);
    end
    do_read(BASE, 8'd3, 10'h011, d, resp, last, rid);
    n_cmp++;
    if (d !== 64'd0 || resp !== 2'b10) begin
      n_err++;
      $display("FAIL slverr_rd_len: data=%h resp=%b required 0 10", d, resp);
    end
`ifdef AXI_CAPTURE_COUNT_EN
    n_cmp++;
    if (wr_count !== 16'(model_cnt)) begin
      n_err++;
      $display("FAIL slverr_count: got %0d required %0d", wr_count, model_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [IDW-1:0] rid; logic [63:0] d; logic last;
    @(negedge clk_i);
    aw_valid = 1'b1; aw_addr = BASE + 64'h20; aw_len = 8'd0; aw_id = 10'h2D2;
    w_valid = 1'b1; w_data = 64'hA5A5_0F0F_C3C3_9696; w_strb = 8'hF0; w_last = 1'b1;
    @(negedge clk_i);
    aw_valid = 1'b0; w_valid = 1'b0;
    model_write(BASE + 64'h20, 64'hA5A5_0F0F_C3C3_9696, 8'hF0);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({b_valid, b_id, b_resp, aw_ready, w_ready} !== {1'b1, 10'h2D2, 2'b00, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_b_hold%0d: b_valid=%b id=%h resp=%b aw_ready=%b w_ready=%b required 1 2d2 00 0 0",
                 c, b_valid, b_id, b_resp, aw_ready, w_ready);
      end
      @(negedge clk_i);
    end
    b_ready = 1'b1;
    @(negedge clk_i);
    b_ready = 1'b0;
    n_cmp++;
    if ({b_valid, aw_ready, w_ready} !== 3'b011) begin
      n_err++;
      $display("FAIL bp_b_release: b_valid,aw_ready,w_ready=%b required 011", {b_valid, aw_ready, w_ready});
    end
    ar_valid = 1'b1; ar_addr = BASE + 64'h20; ar_len = 8'd0; ar_id = 10'h0AA;
    @(negedge clk_i);
    ar_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({r_valid, r_last, r_id, r_data, r_resp, ar_ready} !== {1'b1, 1'b1, 10'h0AA, model_mem[4], 2'b00, 1'b0}) begin
        n_err++;
        $display("FAIL bp_r_hold%0d: r_valid=%b last=%b id=%h data=%h resp=%b ar_ready=%b required 1 1 0aa %h 00 0",
                 c, r_valid, r_last, r_id, r_data, r_resp, ar_ready, model_mem[4]);
      end
      @(negedge clk_i);
    end
    r_ready = 1'b1;
    @(negedge clk_i);
    r_ready = 1'b0;
    do_read(BASE + 64'h20, 8'd0, 10'h0AB, d, resp, last, rid);
  endtask

  task automatic test_same_edge();
    logic [63:0] old_val;
    logic [1:0] resp; logic [IDW-1:0] rid; logic [63:0] d; logic last;
    old_val = model_mem[2];
    @(negedge clk_i);
    aw_valid = 1'b1; aw_addr = BASE + 64'h10; aw_len = 8'd0; aw_id = 10'h101;
    w_valid = 1'b1; w_data = 64'h0123_4567_89AB_CDEF; w_strb = 8'hFF; w_last = 1'b1;
    ar_valid = 1'b1; ar_addr = BASE + 64'h10; ar_len = 8'd0; ar_id = 10'h202;
    @(negedge clk_i);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    n_cmp++;
    if ({r_valid, r_data, r_resp, b_valid, b_resp} !== {1'b1, old_val, 2'b00, 1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL same_edge: r_valid=%b data=%h resp=%b b_valid=%b b_resp=%b required 1 %h 00 1 00",
               r_valid, r_data, r_resp, b_valid, b_resp, old_val);
    end
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk_i);
    b_ready = 1'b0; r_ready = 1'b0;
    model_write(BASE + 64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_read(BASE + 64'h10, 8'd0, 10'h203, d, resp, last, rid);
    n_cmp++;
    if (d !== model_mem[2]) begin
      n_err++;
      $display("FAIL same_edge_after: data=%h required %h", d, model_mem[2]);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; logic [IDW-1:0] bid, rid, id; int lat;
    logic [63:0] d, addr, data, edata; logic last, wl; logic [7:0] len, strb;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE - 64'(8 * $urandom_range(1, 4));
        1:       addr = BASE + 64'h40 + 64'(8 * $urandom_range(0, 10));
        default: addr = BASE + 64'($urandom_range(0, 63));
      endcase
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      id  = 10'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        data = {$urandom, $urandom};
        strb = 8'($urandom);
        wl   = ($urandom_range(0, 7) != 0);
        eresp = legal_wr(addr, len, wl) ? 2'b00 : 2'b10;
        do_write(addr, len, data, strb, wl, id, resp, bid, lat);
        if (eresp == 2'b00) model_write(addr, data, strb);
        n_cmp++;
        if (resp !== eresp || bid !== id) begin
          n_err++;
          $display("FAIL rand_wr%0d: addr=%h resp=%b id=%h required %b %h", i, addr, resp, bid, eresp, id);
        end
      end else begin
        eresp = legal_rd(addr, len) ? 2'b00 : 2'b10;
        edata = (eresp == 2'b00) ? model_mem[word_of(addr)] : 64'd0;
        do_read(addr, len, id, d, resp, last, rid);
        n_cmp++;
        if (d !== edata || resp !== eresp || last !== 1'b1 || rid !== id) begin
          n_err++;
          $display("FAIL rand_rd%0d: addr=%h data=%h resp=%b last=%b id=%h required %h %b 1 %h",
                   i, addr, d, resp, last, rid, edata, eresp, id);
        end
      end
    end
`ifdef AXI_CAPTURE_COUNT_EN
    n_cmp++;
    if (wr_count !== 16'(model_cnt)) begin
      n_err++;
      $display("FAIL rand_count: got %0d required %0d", wr_count, model_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [IDW-1:0] rid; logic [63:0] d; logic last;
    @(negedge clk_i);
    aw_valid = 1'b1; aw_addr = BASE + 64'h30; aw_len = 8'd0; aw_id = 10'h333;
    @(negedge clk_i);
    aw_valid = 1'b0;
    n_cmp++;
    if ({aw_ready, w_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_have_aw: aw_ready,w_ready=%b required 01", {aw_ready, w_ready});
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
    @(posedge clk_i);
    #1;
    n_cmp++;
    if ({aw_ready, w_ready, ar_ready, b_valid, r_valid} !== 5'b11100) begin
      n_err++;
      $display("FAIL mid_release: aw,w,ar ready,b_valid,r_valid=%b required 11100",
               {aw_ready, w_ready, ar_ready, b_valid, r_valid});
    end
    for (int i = 0; i < NW; i++) begin
      do_read(BASE + 64'(i * 8), 8'd0, 10'(i), d, resp, last, rid);
      n_cmp++;
      if (d !== 64'd0 || resp !== 2'b00) begin
        n_err++;
        $display("FAIL mid_mem%0d: data=%h resp=%b required 0 00", i, d, resp);
      end
    end
    // A lone W must not pair with the discarded AW
    @(negedge clk_i);
    w_valid = 1'b1; w_data = 64'hFFFF_0000_FFFF_0000; w_strb = 8'hFF; w_last = 1'b1;
    @(negedge clk_i);
    w_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({b_valid, aw_ready, w_ready} !== 3'b010) begin
        n_err++;
        $display("FAIL mid_no_b%0d: b_valid,aw_ready,w_ready=%b required 010", c, {b_valid, aw_ready, w_ready});
      end
      @(negedge clk_i);
    end
    aw_valid = 1'b1; aw_addr = BASE + 64'h38; aw_len = 8'd0; aw_id = 10'h044;
    @(negedge clk_i);
    aw_valid = 1'b0;
    b_ready = 1'b1;
    @(negedge clk_i);
    b_ready = 1'b0;
    model_write(BASE + 64'h38, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    do_read(BASE + 64'h38, 8'd0, 10'h045, d, resp, last, rid);
    n_cmp++;
    if (d !== model_mem[7]) begin
      n_err++;
      $display("FAIL mid_after: data=%h required %h", d, model_mem[7]);
    end
`ifdef AXI_CAPTURE_COUNT_EN
    n_cmp++;
    if (wr_count !== 16'(model_cnt)) begin
      n_err++;
      $display("FAIL mid_count: got %0d required %0d", wr_count, model_cnt);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_slverr();
    test_backpressure();
    test_same_edge();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
